// File: rtl/rom_sequencer.sv
// Address-generating read sequencer for a small combinational ROM: walks a wrapping
// address range, registers each byte, hands it downstream and keeps a running checksum.
module rom_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);

    // Handshake: a byte transfers on any rising edge where data_valid && data_ready;
    // data_out/data_valid are held stable until then, data_ready alone has no effect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   remaining;
    logic              handshake;

    assign handshake = data_valid && data_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = SEND;
            SEND: begin
                if (handshake) begin
                    state_next = (remaining == '0) ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // remaining is decremented in FETCH, so in SEND it counts bytes still to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            checksum   <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr  <= start_addr;
                        remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
                        checksum  <= '0;
                    end
                end
                FETCH: begin
                    data_out   <= rom_data;
                    data_valid <= 1'b1;
                    rom_addr   <= rom_addr + 1'b1;
                    remaining  <= remaining - 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        checksum   <= checksum + data_out;
                        data_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer with a behavioural 16x8 ROM attached to the address bus.
module tb_rom_sequencer;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    logic [7:0] rom_tbl [0:15] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22,
                                   8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h00};
    assign rom_data = rom_tbl[rom_addr];

    logic [DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
        .rom_addr(rom_addr), .rom_data(rom_data), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int sa, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(rom_tbl[(sa + k) % 16]);
    endtask

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic do_start(input int sa, input int cnt);
        start      = 1'b1;
        start_addr = ADDR_W'(sa);
        count      = (ADDR_W + 1)'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until done (bounded), checking each transferred byte against exp_q.
    task automatic run_cmd(input int budget, input int stall, input int busy_start_at,
                           output int hs, output int dones, output int done_at,
                           output int first_v);
        int stall_left;
        stall_left = 0;
        hs = 0; dones = 0; done_at = -1; first_v = -1;
        for (int i = 0; i < budget; i++) begin
            start = (i == busy_start_at);
            if (start) begin
                start_addr = '0;
                count      = 5'd1;
            end
            if (data_valid && first_v < 0) begin
                first_v    = i;
                stall_left = stall;
            end
            if (stall_left > 0) begin
                data_ready = 1'b0;
                stall_left--;
                check("hold_valid", data_valid, 1);
                if (exp_q.size() > 0) check("hold_data", data_out, exp_q[0]);
            end else begin
                data_ready = 1'b1;
            end
            if (data_valid && data_ready) begin
                hs++;
                if (exp_q.size() > 0) check("byte", data_out, exp_q.pop_front());
            end
            if (done) begin
                dones++;
                done_at = i;
            end
            @(negedge clk);
            if (dones > 0) break;
        end
        start      = 1'b0;
        data_ready = 1'b1;
    endtask

    initial begin
        int hs, dones, done_at, first_v;
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read 0..3
        push_exp(0, 4);
        do_start(0, 4);
        check("basic_busy", busy, 1);
        run_cmd(40, 0, -1, hs, dones, done_at, first_v);
        check("basic_first_valid", first_v, 1);
        check("basic_done_at", done_at, 8);
        check("basic_dones", dones, 1);
        check("basic_hs", hs, 4);
        check("basic_left", exp_q.size(), 0);
        check("basic_checksum", checksum, 8'h0E);
        check("basic_idle_busy", busy, 0);
        check("basic_done_low", done, 0);
        @(negedge clk);
        check("basic_checksum_hold", checksum, 8'h0E);

        // Wrap-around 14,15,0,1
        push_exp(14, 4);
        do_start(14, 4);
        run_cmd(40, 0, -1, hs, dones, done_at, first_v);
        check("wrap_hs", hs, 4);
        check("wrap_dones", dones, 1);
        check("wrap_left", exp_q.size(), 0);
        check("wrap_checksum", checksum, 8'hFE);

        // Backpressure: ready low 3 cycles on the first byte
        push_exp(5, 2);
        do_start(5, 2);
        run_cmd(40, 3, -1, hs, dones, done_at, first_v);
        check("bp_hs", hs, 2);
        check("bp_done_at", done_at, 7);
        check("bp_left", exp_q.size(), 0);
        check("bp_checksum", checksum, 8'h10);

        // Zero count: immediate done, no data
        do_start(9, 0);
        check("zero_valid", data_valid, 0);
        run_cmd(10, 0, -1, hs, dones, done_at, first_v);
        check("zero_done_at", done_at, 0);
        check("zero_dones", dones, 1);
        check("zero_first_valid", first_v, -1);
        check("zero_checksum", checksum, 0);
        check("zero_busy", busy, 0);

        // Saturated count: 20 reads only 16
        push_exp(0, 16);
        do_start(0, 20);
        run_cmd(100, 0, -1, hs, dones, done_at, first_v);
        check("sat_hs", hs, 16);
        check("sat_done_at", done_at, 32);
        check("sat_left", exp_q.size(), 0);
        check("sat_checksum", checksum, 8'hF8);

        // Start while busy is ignored
        push_exp(3, 3);
        do_start(3, 3);
        run_cmd(40, 0, 1, hs, dones, done_at, first_v);
        check("busy_hs", hs, 3);
        check("busy_done_at", done_at, 6);
        check("busy_left", exp_q.size(), 0);
        check("busy_checksum", checksum, 8'hCA);
        @(negedge clk);
        check("busy_no_restart", busy, 0);

        // Reset after two handshakes
        do_start(0, 4);
        repeat (4) @(negedge clk);
        check("mid_checksum", checksum, 8'h65);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rom_addr", rom_addr, 0);
        check("mid_data_out", data_out, 0);
        check("mid_valid", data_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_checksum_clr", checksum, 0);
        @(negedge clk);
        check("mid_no_done", done, 0);

        // Normal command after reset
        push_exp(1, 2);
        do_start(1, 2);
        run_cmd(40, 0, -1, hs, dones, done_at, first_v);
        check("post_hs", hs, 2);
        check("post_done_at", done_at, 4);
        check("post_left", exp_q.size(), 0);
        check("post_checksum", checksum, 8'h87);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
